// File: rtl/soda_vend_controller.sv
// -----------------------------------------------------------------------------
// soda_vend_controller
//   Top-level sequencing FSM for the soda machine. It accumulates coin credit,
//   compares it against PRICE, drives the dispense actuator for DISPENSE_CYCLES
//   cycles using an internal timer, then issues a single change-return pulse.
//
//   Optional feature macro: COIN_RETURN_EN
//     Adds a REFUND state so that cancel in COLLECT returns all credit.
//     With the macro undefined, cancel is ignored.
//
//   All outputs are registered. The output decode looks at the next state, so
//   the flops already hold the values that belong to the state being entered.
// -----------------------------------------------------------------------------
module soda_vend_controller #(
  parameter int PRICE           = 75,
  parameter int CREDIT_W        = 8,
  parameter int DISPENSE_CYCLES = 4,
  parameter int TIMER_W         = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                nickel,
  input  logic                dime,
  input  logic                quarter,
  input  logic                cancel,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output logic                dispense,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change
);

  localparam logic [CREDIT_W-1:0] PRICE_C   = CREDIT_W'(PRICE);
  localparam logic [TIMER_W-1:0]  TIMER_END = TIMER_W'(DISPENSE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_DISPENSE,
    S_CHANGE
`ifdef COIN_RETURN_EN
    , S_REFUND
`endif
  } state_t;

  state_t              state, next_state;
  logic [TIMER_W-1:0]  timer, timer_d;
  logic [CREDIT_W-1:0] credit_d;
  logic [CREDIT_W-1:0] coin_value;
  logic [CREDIT_W-1:0] sum;
  logic                busy_d, dispense_d, change_valid_d;
  logic [CREDIT_W-1:0] change_d;

`ifdef COIN_RETURN_EN
  logic                cancel_req;
  assign cancel_req = cancel;
`else
  // cancel has no function in this build; kept on the port for pin compatibility.
  logic                cancel_unused;
  assign cancel_unused = cancel;
`endif

  // Coin value with strict priority: quarter over dime over nickel.
  always_comb begin
    if (quarter)   coin_value = CREDIT_W'(25);
    else if (dime) coin_value = CREDIT_W'(10);
    else if (nickel) coin_value = CREDIT_W'(5);
    else           coin_value = '0;
  end

  assign sum = credit + coin_value;

  // State, timer, credit and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      timer        <= '0;
      credit       <= '0;
      busy         <= 1'b0;
      dispense     <= 1'b0;
      change_valid <= 1'b0;
      change       <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state        <= next_state;
      timer        <= timer_d;
      credit       <= credit_d;
      busy         <= busy_d;
      dispense     <= dispense_d;
      change_valid <= change_valid_d;
      change       <= change_d;
    end
  end

  // Next-state, next-credit and dispense-timer logic.
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latches).
    next_state = state;
    credit_d   = credit;
    // Timer sits at zero outside DISPENSE, so it is cleared on entry.
    timer_d    = '0;
    unique case (state)
      S_IDLE, S_COLLECT: begin
        if (coin_value != '0) begin
          credit_d   = sum;
          next_state = S_COLLECT;
        end
        // With no coin, sum equals credit, which is always below PRICE here.
        if (sum >= PRICE_C) begin
          next_state = S_DISPENSE;
        end
`ifdef COIN_RETURN_EN
        else if (cancel_req && state == S_COLLECT) begin
          next_state = S_REFUND;
        end
`endif
      end
      S_DISPENSE: begin
        timer_d = timer + 1'b1;
        if (timer == TIMER_END) next_state = S_CHANGE;
      end
      S_CHANGE: begin
        credit_d   = '0;
        next_state = S_IDLE;
      end
`ifdef COIN_RETURN_EN
      S_REFUND: begin
        credit_d   = '0;
        next_state = S_IDLE;
      end
`endif
      default: begin
        credit_d   = '0;
        next_state = S_IDLE;
      end
    endcase
  end

  // Output decode for the state being entered, registered at the same edge.
  always_comb begin
    busy_d         = 1'b0;
    dispense_d     = 1'b0;
    change_valid_d = 1'b0;
    change_d       = '0;
    unique case (next_state)
      S_DISPENSE: begin
        busy_d     = 1'b1;
        dispense_d = 1'b1;
      end
      S_CHANGE: begin
        busy_d = 1'b1;
        if (credit_d > PRICE_C) begin
          change_valid_d = 1'b1;
          change_d       = credit_d - PRICE_C;
        end
      end
`ifdef COIN_RETURN_EN
      S_REFUND: begin
        busy_d         = 1'b1;
        change_valid_d = 1'b1;
        change_d       = credit_d;
      end
`endif
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

endmodule
